// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path: FSM encoding, frame width, half-bit helper.
package uart_pkg;

  localparam int unsigned STATE_W   = 3;
  localparam int unsigned DATA_BITS = 8;

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] START  = 3'd1;
  localparam logic [2:0] DATA   = 3'd2;
  localparam logic [2:0] PARITY = 3'd3;
  localparam logic [2:0] STOP   = 3'd4;
  localparam logic [2:0] BREAK  = 3'd5;

  // Counter value at which the start bit is re-checked (its centre).
  function automatic int unsigned half_bit_cnt(input int unsigned clks_per_bit);
    return (clks_per_bit / 2) - 1;
  endfunction

endpackage

// File: rtl/sync2.sv
// Two-flop synchroniser for asynchronous pins; RST_VAL sets the idle level after reset.
module sync2 #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  // Two-stage capture of the asynchronous input.
  always_ff @(posedge clk) begin
    if (reset) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx_deser.sv
// 8N1 UART receive deserializer with read-strobe register interface.
// Optional even-parity bit and par_err flag when UART_RX_PARITY_EN is defined.
module uart_rx_deser
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 434,
  parameter int unsigned CNT_W        = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  input  logic       rd,
  output logic [7:0] data,
  output logic       ready,
  output logic       frame_err,
  output logic       overrun,
  output logic       busy
`ifdef UART_RX_PARITY_EN
  , output logic     par_err
`endif
);

  localparam int unsigned HALF_BIT = half_bit_cnt(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] HALF_CNT = CNT_W'(HALF_BIT);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(CLKS_PER_BIT - 1);

  logic                 rxs;
  logic                 rxs_prev;
  logic [STATE_W-1:0]   state, state_n;
  logic [CNT_W-1:0]     cnt, cnt_n;
  logic [2:0]           bitidx, bitidx_n;
  logic [DATA_BITS-1:0] shreg, shreg_n;
  logic [7:0]           data_n;
  logic                 ready_n, frame_err_n, overrun_n, busy_n;
`ifdef UART_RX_PARITY_EN
  logic                 par_err_n;
`endif

  sync2 #(.RST_VAL(1'b1)) u_sync_rx (
    .clk   (clk),
    .reset (reset),
    .d     (rx),
    .q     (rxs)
  );

  // State and output registers; reset aborts any frame in progress.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      bitidx    <= '0;
      shreg     <= '0;
      rxs_prev  <= 1'b1;
      data      <= 8'h00;
      ready     <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
      busy      <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_err   <= 1'b0;
`endif
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      bitidx    <= bitidx_n;
      shreg     <= shreg_n;
      rxs_prev  <= rxs;
      data      <= data_n;
      ready     <= ready_n;
      frame_err <= frame_err_n;
      overrun   <= overrun_n;
      busy      <= busy_n;
`ifdef UART_RX_PARITY_EN
      par_err   <= par_err_n;
`endif
    end
  end

  // Next-state and next-output logic; flag sets are placed after the rd clears so they win.
  always_comb begin
    state_n     = state;
    cnt_n       = cnt;
    bitidx_n    = bitidx;
    shreg_n     = shreg;
    data_n      = data;
    ready_n     = ready;
    frame_err_n = frame_err;
    overrun_n   = overrun;
`ifdef UART_RX_PARITY_EN
    par_err_n   = par_err;
`endif

    if (rd) begin
      ready_n     = 1'b0;
      frame_err_n = 1'b0;
      overrun_n   = 1'b0;
`ifdef UART_RX_PARITY_EN
      par_err_n   = 1'b0;
`endif
    end

    case (state)
      IDLE: begin
        cnt_n = '0;
        if (!rxs && rxs_prev) state_n = START;
      end
      START: begin
        if (cnt == HALF_CNT) begin
          cnt_n = '0;
          if (rxs) begin
            state_n = IDLE;
          end else begin
            bitidx_n = '0;
            state_n  = DATA;
          end
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      DATA: begin
        if (cnt == FULL_CNT) begin
          cnt_n    = '0;
          shreg_n  = {rxs, shreg[DATA_BITS-1:1]};
          bitidx_n = bitidx + 3'd1;
          if (bitidx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            state_n = PARITY;
`else
            state_n = STOP;
`endif
          end
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (cnt == FULL_CNT) begin
          cnt_n = '0;
          if (^{shreg, rxs}) par_err_n = 1'b1;
          state_n = STOP;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
`endif
      STOP: begin
        if (cnt == FULL_CNT) begin
          cnt_n = '0;
          if (rxs) begin
            data_n  = shreg;
            ready_n = 1'b1;
            if (ready && !rd) overrun_n = 1'b1;
            state_n = IDLE;
          end else begin
            frame_err_n = 1'b1;
            state_n     = BREAK;
          end
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      BREAK: begin
        cnt_n = '0;
        if (rxs) state_n = IDLE;
      end
      default: begin
        cnt_n   = '0;
        state_n = IDLE;
      end
    endcase

    busy_n = (state_n != IDLE);
  end

endmodule

// File: tb/tb_uart_rx_deser.sv
// Self-checking bench for uart_rx_deser at 16 clk per bit; define UART_RX_PARITY_EN for the parity build.
module tb_uart_rx_deser;

  localparam int unsigned CPB = 16;
`ifdef UART_RX_PARITY_EN
  localparam int unsigned LAT = 155 + CPB;
`else
  localparam int unsigned LAT = 155;
`endif

  logic       clk = 1'b0;
  logic       reset, rx, rd;
  logic [7:0] data;
  logic       ready, frame_err, overrun, busy;
`ifdef UART_RX_PARITY_EN
  logic       par_err;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  logic [7:0] sb_q[$];
  logic       sb_en = 1'b1;
  logic       ready_seen = 1'b0;

  typedef struct {
    logic [7:0] tx;
    logic       stop;
    logic [7:0] exp_data;
    logic       exp_ready;
    logic       exp_ferr;
  } vec_t;
  vec_t vecs[6];

  uart_rx_deser #(.CLKS_PER_BIT(CPB), .CNT_W(16)) dut (
    .clk       (clk),
    .reset     (reset),
    .rx        (rx),
    .rd        (rd),
    .data      (data),
    .ready     (ready),
    .frame_err (frame_err),
    .overrun   (overrun),
    .busy      (busy)
`ifdef UART_RX_PARITY_EN
    , .par_err (par_err)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bit(input logic v);
    rx = v;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] tx, input logic stop, input logic par);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(tx[i]);
`ifdef UART_RX_PARITY_EN
    send_bit(par);
`else
    if (par) rx = 1'b1;
`endif
    send_bit(stop);
    rx = 1'b1;
  endtask

  task automatic do_rd();
    rd = 1'b1;
    @(negedge clk);
    rd = 1'b0;
  endtask

  // Scoreboard: compare each newly presented byte against the oldest expected one.
  always @(negedge clk) begin
    if (sb_en && ready && !ready_seen) begin
      if (sb_q.size() == 0) check("sb_unexpected_byte", 32'(data), 32'hFFFF_FFFF);
      else check("sb_data", 32'(data), 32'(sb_q.pop_front()));
    end
    ready_seen = ready;
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{tx: 8'h00, stop: 1'b1, exp_data: 8'h00, exp_ready: 1'b1, exp_ferr: 1'b0};
    vecs[1] = '{tx: 8'hFF, stop: 1'b1, exp_data: 8'hFF, exp_ready: 1'b1, exp_ferr: 1'b0};
    vecs[2] = '{tx: 8'hA5, stop: 1'b1, exp_data: 8'hA5, exp_ready: 1'b1, exp_ferr: 1'b0};
    vecs[3] = '{tx: 8'h5A, stop: 1'b0, exp_data: 8'hA5, exp_ready: 1'b0, exp_ferr: 1'b1};
    vecs[4] = '{tx: 8'h01, stop: 1'b1, exp_data: 8'h01, exp_ready: 1'b1, exp_ferr: 1'b0};
    vecs[5] = '{tx: 8'h80, stop: 1'b1, exp_data: 8'h80, exp_ready: 1'b1, exp_ferr: 1'b0};

    reset = 1'b1; rx = 1'b1; rd = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    check("rst_data", 32'(data), 32'h00);
    check("rst_ready", 32'(ready), 0);
    check("rst_frame_err", 32'(frame_err), 0);
    check("rst_overrun", 32'(overrun), 0);
    check("rst_busy", 32'(busy), 0);
    idle(4);

    // 0x55 with exact latency from the pin falling edge.
    sb_q.push_back(8'h55);
    fork
      send_frame(8'h55, 1'b1, 1'b0);
      begin
        repeat (LAT - 1) @(posedge clk);
        #1 check("lat_ready_before", 32'(ready), 0);
        @(posedge clk);
        #1 check("lat_ready_at", 32'(ready), 1);
      end
    join
    idle(4);
    check("f55_data", 32'(data), 32'h55);
    check("f55_frame_err", 32'(frame_err), 0);
    check("f55_sb_drain", 32'(sb_q.size()), 0);
    do_rd();
    check("f55_rd_ready", 32'(ready), 0);

    // Table of frames, each read back afterwards.
    for (int i = 0; i < 6; i++) begin
      if (vecs[i].stop) sb_q.push_back(vecs[i].tx);
      send_frame(vecs[i].tx, vecs[i].stop, ^vecs[i].tx);
      idle(8);
      check("vec_sb_drain", 32'(sb_q.size()), 0);
      check("vec_data", 32'(data), 32'(vecs[i].exp_data));
      check("vec_ready", 32'(ready), 32'(vecs[i].exp_ready));
      check("vec_frame_err", 32'(frame_err), 32'(vecs[i].exp_ferr));
      check("vec_busy", 32'(busy), 0);
      do_rd();
      check("vec_rd_ready", 32'(ready), 0);
      check("vec_rd_frame_err", 32'(frame_err), 0);
      idle(4);
    end

    // Overrun: second byte arrives while the first is unread.
    sb_en = 1'b0;
    send_frame(8'hA3, 1'b1, ^8'hA3);
    idle(2);
    send_frame(8'h3C, 1'b1, ^8'h3C);
    idle(4);
    check("ovr_data", 32'(data), 32'h3C);
    check("ovr_overrun", 32'(overrun), 1);
    check("ovr_ready", 32'(ready), 1);
    do_rd();
    check("ovr_rd_ready", 32'(ready), 0);
    check("ovr_rd_overrun", 32'(overrun), 0);
    idle(2);
    sb_en = 1'b1;

    // False start: 6 clk low pulse.
    rx = 1'b0;
    repeat (5) @(negedge clk);
    check("fs_busy_mid", 32'(busy), 1);
    @(negedge clk);
    rx = 1'b1;
    repeat (6) @(negedge clk);
    check("fs_busy_end", 32'(busy), 0);
    check("fs_ready", 32'(ready), 0);
    idle(CPB * 2);
    check("fs_ready_late", 32'(ready), 0);

    // Framing error with the line held low afterwards.
    send_frame(8'h81, 1'b0, ^8'h81);
    rx = 1'b0;
    repeat (40) @(negedge clk);
    check("fe_frame_err", 32'(frame_err), 1);
    check("fe_ready", 32'(ready), 0);
    check("fe_data", 32'(data), 32'h3C);
    check("fe_busy_break", 32'(busy), 1);
    rx = 1'b1;
    idle(6);
    check("fe_busy_idle", 32'(busy), 0);
    check("fe_ready_idle", 32'(ready), 0);
    do_rd();
    check("fe_rd_clear", 32'(frame_err), 0);
    idle(4);

    // Reset pulse during data bit 4 of 0xF0.
    fork
      send_frame(8'hF0, 1'b1, ^8'hF0);
      begin
        repeat (CPB * 5 + CPB / 2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("mr_data", 32'(data), 32'h00);
        check("mr_ready", 32'(ready), 0);
        check("mr_busy", 32'(busy), 0);
        check("mr_frame_err", 32'(frame_err), 0);
        check("mr_overrun", 32'(overrun), 0);
      end
    join
    idle(4);
    check("mr_after_ready", 32'(ready), 0);
    check("mr_after_busy", 32'(busy), 0);
    sb_q.push_back(8'h0F);
    send_frame(8'h0F, 1'b1, ^8'h0F);
    idle(4);
    check("mr_clean_sb_drain", 32'(sb_q.size()), 0);
    check("mr_clean_data", 32'(data), 32'h0F);
    check("mr_clean_ready", 32'(ready), 1);
    do_rd();
    idle(4);

`ifdef UART_RX_PARITY_EN
    // Bad parity: byte still delivered, par_err raised.
    sb_q.push_back(8'h07);
    send_frame(8'h07, 1'b1, 1'b0);
    idle(4);
    check("par_err", 32'(par_err), 1);
    check("par_ready", 32'(ready), 1);
    check("par_data", 32'(data), 32'h07);
    do_rd();
    check("par_rd_clear", 32'(par_err), 0);
    idle(4);
`endif

    check("final_sb_empty", 32'(sb_q.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
